// File: rtl/aq_dcache_data_array_banked_pkg.sv
// Shared constants, field helpers and payload types for the banked dcache data array.
package aq_dcache_data_array_banked_pkg;

    localparam int unsigned DFLT_NUM_BANK   = 2;
    localparam int unsigned DFLT_DEPTH      = 512;
    localparam int unsigned DFLT_RD_LAT     = 1;
    localparam int unsigned DFLT_STARVE_MAX = 4;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned BYTE_OFS_W = 3;
    localparam int unsigned CNT_W      = 4;

    // SRAM macro pins are active low
    localparam logic SRAM_EN  = 1'b0;
    localparam logic SRAM_DIS = 1'b1;
    localparam logic SRAM_WR  = 1'b0;
    localparam logic SRAM_RD  = 1'b1;

    // Write data plus byte enables as delivered to a bank
    typedef struct packed {
        logic [DATA_W-1:0] din;
        logic [BE_W-1:0]   be;
    } wr_payload_t;

    // Byte index width for a given geometry
    function automatic int unsigned idx_width(input int unsigned nb, input int unsigned depth);
        return $clog2(nb * depth) + BYTE_OFS_W;
    endfunction

    // Low bit of the bank field (the bank field itself is $clog2(nb) wide)
    function automatic int unsigned bank_lsb();
        return BYTE_OFS_W;
    endfunction

    // Low bit of the row field
    function automatic int unsigned row_lsb(input int unsigned nb);
        return BYTE_OFS_W + $clog2(nb);
    endfunction

endpackage

// File: rtl/aq_dcache_data_array_banked_macros.sv
// Behavioural stand-ins for the clock-gate cell and the 64-bit-wide single-port SRAM macros.

// Latch-based clock gate: enable is captured while the clock is low
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    logic clk_en_bf_latch;
    logic clk_en_lat;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    // Transparent-low enable latch keeps the gated clock glitch free
    always_latch begin
        if (!clk_in) clk_en_lat = clk_en_bf_latch | pad_yy_icg_scan_en;
    end

    assign clk_out = clk_in & clk_en_lat;
endmodule

// Generic single-port SRAM core, active-low controls and bit write mask
module aq_spsram_core #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          gwen,
    input  logic [63:0]   wen,
    input  logic [AW-1:0] a,
    input  logic [63:0]   d,
    output logic [63:0]   q
);
    logic [63:0] mem_q [DEPTH];

    // Masked write or read; q holds its value while not read
    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!gwen) mem_q[a] <= (mem_q[a] & wen) | (d & ~wen);
            else       q        <= mem_q[a];
        end
    end
endmodule

module aq_spsram_128x64 (
    input logic clk, input logic cen, input logic gwen, input logic [63:0] wen,
    input logic [6:0] a, input logic [63:0] d, output logic [63:0] q
);
    aq_spsram_core #(.DEPTH(128)) u_core (.*);
endmodule

module aq_spsram_256x64 (
    input logic clk, input logic cen, input logic gwen, input logic [63:0] wen,
    input logic [7:0] a, input logic [63:0] d, output logic [63:0] q
);
    aq_spsram_core #(.DEPTH(256)) u_core (.*);
endmodule

module aq_spsram_512x64 (
    input logic clk, input logic cen, input logic gwen, input logic [63:0] wen,
    input logic [8:0] a, input logic [63:0] d, output logic [63:0] q
);
    aq_spsram_core #(.DEPTH(512)) u_core (.*);
endmodule

module aq_spsram_1024x64 (
    input logic clk, input logic cen, input logic gwen, input logic [63:0] wen,
    input logic [9:0] a, input logic [63:0] d, output logic [63:0] q
);
    aq_spsram_core #(.DEPTH(1024)) u_core (.*);
endmodule

module aq_spsram_2048x64 (
    input logic clk, input logic cen, input logic gwen, input logic [63:0] wen,
    input logic [10:0] a, input logic [63:0] d, output logic [63:0] q
);
    aq_spsram_core #(.DEPTH(2048)) u_core (.*);
endmodule

// File: rtl/aq_dcache_data_bank.sv
// One data bank: private clock gate plus a DEPTH x 64 SRAM macro with byte-enable expansion.
module aq_dcache_data_bank
    import aq_dcache_data_array_banked_pkg::*;
#(
    parameter int unsigned DEPTH = DFLT_DEPTH,
    parameter int unsigned ROW_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              icg_en_i,
    input  logic              scan_en_i,
    input  logic              cen_i,
    input  logic              gwen_i,
    input  logic [ROW_W-1:0]  addr_i,
    input  wr_payload_t       wr_i,
    output logic [DATA_W-1:0] q_o
);
    logic              local_en;
    logic              gclk;
    logic [DATA_W-1:0] wen;

    // The bank is only clocked in cycles where it is accessed
    assign local_en = (cen_i == SRAM_EN);

    gated_clk_cell u_icg (
        .clk_in             (clk_i),
        .global_en          (1'b1),
        .module_en          (icg_en_i),
        .local_en           (local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (scan_en_i),
        .clk_out            (gclk)
    );

    // Expand each byte enable into eight active-low bit write enables
    always_comb begin
        wen = '1;
        for (int unsigned i = 0; i < BE_W; i++) begin
            wen[i*8 +: 8] = wr_i.be[i] ? {8{SRAM_WR}} : {8{SRAM_RD}};
        end
    end

    // Pick the macro matching the bank depth
    case (DEPTH)
        128: begin : g_128
            aq_spsram_128x64 u_sram (.clk(gclk), .cen(cen_i), .gwen(gwen_i), .wen(wen),
                                     .a(addr_i), .d(wr_i.din), .q(q_o));
        end
        256: begin : g_256
            aq_spsram_256x64 u_sram (.clk(gclk), .cen(cen_i), .gwen(gwen_i), .wen(wen),
                                     .a(addr_i), .d(wr_i.din), .q(q_o));
        end
        512: begin : g_512
            aq_spsram_512x64 u_sram (.clk(gclk), .cen(cen_i), .gwen(gwen_i), .wen(wen),
                                     .a(addr_i), .d(wr_i.din), .q(q_o));
        end
        1024: begin : g_1024
            aq_spsram_1024x64 u_sram (.clk(gclk), .cen(cen_i), .gwen(gwen_i), .wen(wen),
                                      .a(addr_i), .d(wr_i.din), .q(q_o));
        end
        2048: begin : g_2048
            aq_spsram_2048x64 u_sram (.clk(gclk), .cen(cen_i), .gwen(gwen_i), .wen(wen),
                                      .a(addr_i), .d(wr_i.din), .q(q_o));
        end
        default: begin : g_no_macro
            assign q_o = '0;
        end
    endcase

endmodule

// File: rtl/aq_dcache_data_array_banked.sv
// Banked dcache data array: load/write port arbitration, starvation guard, read pipe and output mux.
module aq_dcache_data_array_banked
    import aq_dcache_data_array_banked_pkg::*;
#(
    parameter int unsigned NUM_BANK   = DFLT_NUM_BANK,
    parameter int unsigned DEPTH      = DFLT_DEPTH,
    parameter int unsigned RD_LAT     = DFLT_RD_LAT,
    parameter int unsigned STARVE_MAX = DFLT_STARVE_MAX,
    parameter int unsigned IDX_W      = idx_width(NUM_BANK, DEPTH)
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              cp0_lsu_icg_en,
    input  logic              pad_yy_icg_scan_en,
    input  logic              ld_req_vld,
    input  logic [IDX_W-1:0]  ld_req_idx,
    output logic              ld_req_rdy,
    output logic              ld_rsp_vld,
    output logic [DATA_W-1:0] ld_rsp_data,
    input  logic              wr_req_vld,
    input  logic [IDX_W-1:0]  wr_req_idx,
    input  logic [DATA_W-1:0] wr_req_din,
    input  logic [BE_W-1:0]   wr_req_be,
    output logic              wr_req_rdy
);
    localparam int unsigned BANK_W  = $clog2(NUM_BANK);
    localparam int unsigned BSEL_W  = (BANK_W == 0) ? 1 : BANK_W;
    localparam int unsigned ROW_W   = $clog2(DEPTH);
    localparam int unsigned ROW_LSB = row_lsb(NUM_BANK);

    logic [BSEL_W-1:0] ld_bank, wr_bank;
    logic [ROW_W-1:0]  ld_row, wr_row;
    logic              same_bank, conflict, starve_full;
    logic              ld_fire, wr_fire;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              rd_vld_q;
    logic [BSEL_W-1:0] rd_bank_q;
    logic [DATA_W-1:0] rd_mux_c;
    logic [DATA_W-1:0] bank_q [NUM_BANK];
    wr_payload_t       wr_pl;
    logic              unused_idx_bits;

    // Byte offset within the 64-bit word does not select anything
    assign unused_idx_bits = ^{ld_req_idx[BYTE_OFS_W-1:0], wr_req_idx[BYTE_OFS_W-1:0]};

    // Index decode; a single-bank array has no bank field
    if (NUM_BANK > 1) begin : g_bank_field
        assign ld_bank = ld_req_idx[bank_lsb() +: BANK_W];
        assign wr_bank = wr_req_idx[bank_lsb() +: BANK_W];
    end else begin : g_one_bank
        assign ld_bank = '0;
        assign wr_bank = '0;
    end
    assign ld_row = ld_req_idx[IDX_W-1:ROW_LSB];
    assign wr_row = wr_req_idx[IDX_W-1:ROW_LSB];

    // Arbitration: writes win a bank conflict until the load has been starved long enough
    assign same_bank   = (ld_bank == wr_bank);
    assign conflict    = ld_req_vld && wr_req_vld && same_bank;
    assign starve_full = (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign ld_req_rdy  = !(wr_req_vld && same_bank && !starve_full);
    assign wr_req_rdy  = !(ld_req_vld && same_bank && starve_full);
    assign ld_fire     = ld_req_vld && ld_req_rdy;
    assign wr_fire     = wr_req_vld && wr_req_rdy;

    // Starve counter next state: count denied loads, clear once a load gets through
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (conflict) begin
            starve_cnt_d = starve_full ? '0 : starve_cnt_q + CNT_W'(1);
        end else if (ld_fire) begin
            starve_cnt_d = '0;
        end
    end

    // Starve counter register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) starve_cnt_q <= '0;
        else           starve_cnt_q <= starve_cnt_d;
    end

    assign wr_pl = '{din: wr_req_din, be: wr_req_be};

    // Per-bank SRAM control: the write address wins only when the write targets this bank
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic             ld_hit, wr_hit, cen, gwen;
        logic [ROW_W-1:0] addr;

        assign ld_hit = ld_fire && (ld_bank == BSEL_W'(b));
        assign wr_hit = wr_fire && (wr_bank == BSEL_W'(b));
        assign cen    = (ld_hit || wr_hit) ? SRAM_EN : SRAM_DIS;
        assign gwen   = wr_hit ? SRAM_WR : SRAM_RD;
        assign addr   = wr_hit ? wr_row : ld_row;

        aq_dcache_data_bank #(.DEPTH(DEPTH), .ROW_W(ROW_W)) u_bank (
            .clk_i     (forever_cpuclk),
            .icg_en_i  (cp0_lsu_icg_en),
            .scan_en_i (pad_yy_icg_scan_en),
            .cen_i     (cen),
            .gwen_i    (gwen),
            .addr_i    (addr),
            .wr_i      (wr_pl),
            .q_o       (bank_q[b])
        );
    end

    // First read stage: remember that a load was issued and which bank holds its data
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld_q  <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            rd_vld_q <= ld_fire;
            if (ld_fire) rd_bank_q <= ld_bank;
        end
    end

    // Select the SRAM output of the bank that was read
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned b = 0; b < NUM_BANK; b++) begin
            if (rd_bank_q == BSEL_W'(b)) rd_mux_c = bank_q[b];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              rsp_vld_q;
        logic [DATA_W-1:0] rsp_data_q;

        // Extra output flop stage; data is zero whenever no response is valid
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                rsp_vld_q  <= 1'b0;
                rsp_data_q <= '0;
            end else begin
                rsp_vld_q  <= rd_vld_q;
                rsp_data_q <= rd_vld_q ? rd_mux_c : '0;
            end
        end

        assign ld_rsp_vld  = rsp_vld_q;
        assign ld_rsp_data = rsp_data_q;
    end else begin : g_lat1
        assign ld_rsp_vld  = rd_vld_q;
        assign ld_rsp_data = rd_vld_q ? rd_mux_c : '0;
    end

endmodule

// File: tb/tb_aq_dcache_data_array_banked.sv
// Scoreboard bench: one RD_LAT=1 and one RD_LAT=2 array driven by identical stimulus.
module tb_aq_dcache_data_array_banked;
    import aq_dcache_data_array_banked_pkg::*;

    localparam int unsigned NB   = 2;
    localparam int unsigned DP   = 512;
    localparam int unsigned SMAX = 4;
    localparam int unsigned IW   = idx_width(NB, DP);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_vld, wr_vld;
    logic [IW-1:0] ld_idx, wr_idx;
    logic [63:0]   wr_din;
    logic [7:0]    wr_be;
    logic          lr1, wr1, rv1, lr2, wr2, rv2;
    logic [63:0]   rd1, rd2;

    always #5 clk = ~clk;

    aq_dcache_data_array_banked #(.NUM_BANK(NB), .DEPTH(DP), .RD_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .cp0_lsu_icg_en(1'b0), .pad_yy_icg_scan_en(1'b0),
        .ld_req_vld(ld_vld), .ld_req_idx(ld_idx), .ld_req_rdy(lr1),
        .ld_rsp_vld(rv1), .ld_rsp_data(rd1),
        .wr_req_vld(wr_vld), .wr_req_idx(wr_idx), .wr_req_din(wr_din), .wr_req_be(wr_be),
        .wr_req_rdy(wr1));

    aq_dcache_data_array_banked #(.NUM_BANK(NB), .DEPTH(DP), .RD_LAT(2), .STARVE_MAX(SMAX)) u_dut2 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .cp0_lsu_icg_en(1'b0), .pad_yy_icg_scan_en(1'b0),
        .ld_req_vld(ld_vld), .ld_req_idx(ld_idx), .ld_req_rdy(lr2),
        .ld_rsp_vld(rv2), .ld_rsp_data(rd2),
        .wr_req_vld(wr_vld), .wr_req_idx(wr_idx), .wr_req_din(wr_din), .wr_req_be(wr_be),
        .wr_req_rdy(wr2));

    typedef struct {
        int          due;
        logic [63:0] data;
        bit          known;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    logic [63:0] mem [int];
    int          starve;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] widx(input int w);
        return IW'(w * 8);
    endfunction

    // Monitor for the RD_LAT=1 array
    always @(negedge clk) begin
        if (rv1) begin
            if (q1.size() == 0) check("rsp1_unexpected", 64'(rv1), 64'd0);
            else begin
                e1 = q1.pop_front();
                check("rsp1_cycle", 64'(cyc), 64'(e1.due));
                if (e1.known) check("rsp1_data", rd1, e1.data);
            end
        end else begin
            check("rsp1_zero", rd1, 64'd0);
            if (q1.size() != 0 && q1[0].due <= cyc) begin
                void'(q1.pop_front());
                check("rsp1_missing", 64'(rv1), 64'd1);
            end
        end
    end

    // Monitor for the RD_LAT=2 array
    always @(negedge clk) begin
        if (rv2) begin
            if (q2.size() == 0) check("rsp2_unexpected", 64'(rv2), 64'd0);
            else begin
                e2 = q2.pop_front();
                check("rsp2_cycle", 64'(cyc), 64'(e2.due));
                if (e2.known) check("rsp2_data", rd2, e2.data);
            end
        end else begin
            check("rsp2_zero", rd2, 64'd0);
            if (q2.size() != 0 && q2[0].due <= cyc) begin
                void'(q2.pop_front());
                check("rsp2_missing", 64'(rv2), 64'd1);
            end
        end
    end

    // One request cycle: drive, check ready against the arbitration rules, update the model
    task automatic cycle(input bit lv, input logic [IW-1:0] li, input bit wv,
                         input logic [IW-1:0] wi, input logic [63:0] wd, input logic [7:0] be);
        int   lw, ww;
        bit   same, exp_lr, exp_wr;
        exp_t e;
        logic [63:0] nv;
        ld_vld = lv; ld_idx = li; wr_vld = wv; wr_idx = wi; wr_din = wd; wr_be = be;
        lw = int'(li >> 3);
        ww = int'(wi >> 3);
        same   = ((lw % NB) == (ww % NB));
        exp_lr = !(wv && same && starve < int'(SMAX));
        exp_wr = !(lv && same && starve == int'(SMAX));
        @(negedge clk);
        check("ld_rdy1", 64'(lr1), 64'(exp_lr));
        check("wr_rdy1", 64'(wr1), 64'(exp_wr));
        check("ld_rdy2", 64'(lr2), 64'(exp_lr));
        check("wr_rdy2", 64'(wr2), 64'(exp_wr));
        if (lv && exp_lr) begin
            e.known = mem.exists(lw);
            e.data  = e.known ? mem[lw] : 64'd0;
            e.due   = cyc + 1;
            q1.push_back(e);
            e.due   = cyc + 2;
            q2.push_back(e);
        end
        if (wv && exp_wr) begin
            if (mem.exists(ww) || be == 8'hFF) begin
                nv = mem.exists(ww) ? mem[ww] : 64'd0;
                for (int i = 0; i < 8; i++) if (be[i]) nv[i*8 +: 8] = wd[i*8 +: 8];
                mem[ww] = nv;
            end
        end
        if (lv && wv && same) starve = (starve < int'(SMAX)) ? starve + 1 : 0;
        else if (lv) starve = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0, '0, 64'd0, 8'h00);
    endtask

    task automatic init_words();
        for (int w = 0; w < 16; w++) cycle(1'b0, '0, 1'b1, widx(w), {$urandom, $urandom}, 8'hFF);
    endtask

    task automatic bank0_conflict(input int n);
        repeat (n) cycle(1'b1, widx(2), 1'b1, widx(4), {$urandom, $urandom}, 8'hFF);
    endtask

    // Asynchronous reset in the middle of a cycle; pending responses and array contents are lost
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        mem.delete();
        starve = 0;
        idle(n);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; starve = 0;
        ld_vld = 1'b0; ld_idx = '0; wr_vld = 1'b0; wr_idx = '0; wr_din = '0; wr_be = '0;
        @(posedge clk);
        #1;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        init_words();

        // Full write then read back, then partial write merge
        cycle(1'b0, '0, 1'b1, IW'(13'h008), 64'h1122334455667788, 8'hFF);
        cycle(1'b1, IW'(13'h008), 1'b0, '0, 64'd0, 8'h00);
        idle(3);
        check("model_full_write", mem[1], 64'h1122334455667788);
        cycle(1'b0, '0, 1'b1, IW'(13'h008), 64'hFFFFFFFF_AAAAAAAA, 8'h0F);
        cycle(1'b1, IW'(13'h008), 1'b0, '0, 64'd0, 8'h00);
        idle(3);
        check("model_partial_write", mem[1], 64'h11223344_AAAAAAAA);

        // Load bank0 alongside a write to bank1, then read the written word
        cycle(1'b1, widx(0), 1'b1, widx(3), 64'hDEADBEEF_0BADF00D, 8'hFF);
        cycle(1'b1, widx(3), 1'b0, '0, 64'd0, 8'h00);
        idle(3);

        // Sustained same-bank conflict: four denied loads, then the load wins, then writes again
        bank0_conflict(6);
        idle(3);

        // Back-to-back loads across banks
        cycle(1'b1, widx(2), 1'b0, '0, 64'd0, 8'h00);
        cycle(1'b1, widx(5), 1'b0, '0, 64'd0, 8'h00);
        cycle(1'b1, widx(4), 1'b0, '0, 64'd0, 8'h00);
        idle(3);

        // Random traffic over a small set of words in both banks
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), widx(int'($urandom_range(0, 15))),
                  1'($urandom), widx(int'($urandom_range(0, 15))),
                  {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
        end
        idle(3);

        // Reset right after a load is accepted drops its response
        cycle(1'b1, widx(1), 1'b0, '0, 64'd0, 8'h00);
        do_reset(3);
        idle(2);
        init_words();

        // Reset in the middle of a conflict clears the starve counter
        bank0_conflict(3);
        do_reset(2);
        bank0_conflict(6);
        idle(4);

        check("drain1", 64'(q1.size()), 64'd0);
        check("drain2", 64'(q2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aq_dcache_data_array_banked.md
Name: aq_dcache_data_array_banked

Overview:
Parametrised, multi-bank successor to the single-macro dcache data array. It holds NUM_BANK banks of DEPTH x 64 single-port SRAM, each behind its own clock gate. A load-read port and a refill/store write port share the banks, with per-bank conflict arbitration, a starvation guard and a configurable read latency. It sits in the LSU between the load pipeline / refill unit and the dcache SRAM macros.

Parameters:
NUM_BANK, 2, number of 64-bit banks; power of two, 1..8
DEPTH, 512, entries per bank; power of two, 128..2048
RD_LAT, 1, load latency from acceptance to ld_rsp_vld; legal values 1 or 2 (2 adds an output register)
STARVE_MAX, 4, consecutive conflict-denied load cycles before the load port takes priority; 1..15
IDX_W, derived, log2(NUM_BANK*DEPTH)+3; byte index width

Ports:
forever_cpuclk  in  1  free-running core clock
cpurst_b  in  1  asynchronous active-low reset
cp0_lsu_icg_en  in  1  module-level clock-gate enable
pad_yy_icg_scan_en  in  1  scan enable to the clock gates
ld_req_vld  in  1  load read request
ld_req_idx  in  IDX_W  load byte index
ld_req_rdy  out  1  load accepted this cycle
ld_rsp_vld  out  1  load data valid
ld_rsp_data  out  64  load data
wr_req_vld  in  1  write request
wr_req_idx  in  IDX_W  write byte index
wr_req_din  in  64  write data
wr_req_be  in  8  byte enables, active high
wr_req_rdy  out  1  write accepted this cycle

Behaviour:
- Index decode: [2:0] ignored; bank = idx[3 +: log2(NUM_BANK)]; row = idx[IDX_W-1 : 3+log2(NUM_BANK)]. When NUM_BANK=1 the bank field is absent.
- Per bank, SRAM pins are active low. CEN=0 when the bank is accessed; GWEN=0 on a write; WEN bit i = ~wr_req_be[i/8].
- Clock gate local_en = the bank is accessed this cycle. Idle banks are not clocked.
- Handshake: a request fires when vld && rdy, in the same cycle. Combinational rdy must not depend on its own port's vld.
  - Banks differ, or only one port is valid: both ready.
  - Same bank, starve_cnt < STARVE_MAX: write wins; ld_req_rdy=0, starve_cnt++.
  - Same bank, starve_cnt == STARVE_MAX: load wins; wr_req_rdy=0, starve_cnt cleared.
  - Accepted load with no conflict: starve_cnt cleared.
  - Saturates at STARVE_MAX.
- Read path:
  - Accepted load registers its bank id and a pipe valid.
  - RD_LAT=1: ld_rsp_vld one cycle after acceptance; data muxed from the registered bank's Q.
  - RD_LAT=2: an additional flop stage; ld_rsp_vld two cycles after acceptance.
  - Back-to-back loads produce back-to-back responses. No response back-pressure.
- ld_rsp_data is forced to 0 whenever ld_rsp_vld=0.
- Write completes in the accept cycle. A load to the same row accepted the next cycle returns the new data; no bypass is needed.
- Load and write to the same bank in the same cycle never both fire.
- Reset, asynchronous: ld_rsp_vld=0, ld_rsp_data=0, pipe valids=0, starve_cnt=0.
  - Reset mid-flight drops pending responses; SRAM contents are undefined.
  - rdy outputs are combinational and are 1 while in reset only if the port's bank is free; callers must not issue requests during reset.

Decomposition:
- Shared package/define file: NUM_BANK/DEPTH defaults, IDX_W derivation, bank/row field macros, SRAM pin-polarity constants.
- One sub-module, aq_dcache_data_bank: gated_clk_cell plus an aq_spsram_<DEPTH>x64 instance, selected by a generate on DEPTH, with the byte-enable-to-WEN expansion.
- The top level holds the arbitration, starve counter, read pipe and output mux.

Test Plan:
- Write 0x1122334455667788 to idx 0x008 (bank1, row0), all be; then load idx 0x008 -> ld_rsp_vld after RD_LAT cycles, data 0x1122334455667788.
- Partial write, be=8'h0F, data 0xFFFFFFFF_AAAAAAAA to the same idx; then load -> 0x11223344_AAAAAAAA.
- Load bank0 and write bank1 in the same cycle -> both rdy=1; response returns bank0 data; a later read of bank1 shows the write.
- Same-bank conflict held for STARVE_MAX+1 cycles, default 4 -> ld_req_rdy=0 for 4 cycles, then ld_req_rdy=1 with wr_req_rdy=0 in cycle 5; counter returns to 0.
- Three back-to-back loads to different banks, RD_LAT=2 -> three consecutive ld_rsp_vld cycles starting 2 cycles after the first acceptance, in order.
- Assert cpurst_b low one cycle after a load is accepted -> ld_rsp_vld stays 0 and ld_rsp_data=0; starve_cnt=0 after release.
